// File: rtl/send_board_uart.sv
// send_board_uart: prints the latched tic-tac-toe board as ASCII rows, each ending in CR LF, over a byte UART
module send_board_uart #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter logic [7:0] CHAR_A = 8'h6F,
  parameter logic [7:0] CHAR_B = 8'h78,
  parameter logic [7:0] CHAR_EMPTY = 8'h2E,
  parameter logic [7:0] CHAR_BAD = 8'h23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [ROWS*COLS-1:0] board_a,
  input  logic [ROWS*COLS-1:0] board_b,
  output logic                 ready,
  output logic                 done,
  output logic                 uart_wr,
  output logic [7:0]           uart_d,
  input  logic                 uart_ready
);
  localparam int N = ROWS * COLS;
  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;
  typedef enum logic [1:0] {CELL, CR, LF} phase_t;
  state_t state, state_n;
  phase_t phase;
  logic busy;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [N-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic [7:0] cur;
  logic issue;
  assign ready = !req && !busy;
  assign issue = state == SEND && uart_ready;
  assign idx = IW'(row) * IW'(COLS) + IW'(col);
  assign cur = phase == CR ? 8'h0D :
               phase == LF ? 8'h0A :
               a_q[idx] ? (b_q[idx] ? CHAR_BAD : CHAR_A) :
                          (b_q[idx] ? CHAR_B : CHAR_EMPTY);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // row only reaches ROWS once the final LF has been issued
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = req ? SEND : IDLE;
      SEND:    state_n = uart_ready ? GAP : SEND;
      GAP:     state_n = row == RW'(ROWS) ? FINISH : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      busy <= 1'b1;
      done <= 1'b0;
      uart_wr <= 1'b0;
      uart_d <= 8'h00;
      row <= '0;
      col <= '0;
      phase <= CELL;
      a_q <= '0;
      b_q <= '0;
    end else begin
      uart_wr <= issue;
      done <= state == FINISH;
      if (state == IDLE) begin
        busy <= req;
        if (req) begin
          a_q <= board_a;
          b_q <= board_b;
          row <= '0;
          col <= '0;
          phase <= CELL;
        end
      end
      if (issue) begin
        uart_d <= cur;
        if (phase == CELL) begin
          if (col == CW'(COLS - 1)) phase <= CR;
          else col <= col + CW'(1);
        end else if (phase == CR) phase <= LF;
        else begin
          phase <= CELL;
          col <= '0;
          row <= row + RW'(1);
        end
      end
    end
endmodule

// File: tb/tb_send_board_uart.sv
// tb_send_board_uart: directed checks of the board printer against hand-written expected text
module tb_send_board_uart;
  logic clk = 0, reset, req, ready, done, uart_wr, uart_ready;
  logic [8:0] board_a, board_b;
  logic [7:0] uart_d;
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt, bad_sp, last_wr, first_wr, done_gap, acc;
  byte rx[$];
  send_board_uart dut (.clk(clk), .reset(reset), .req(req), .board_a(board_a), .board_b(board_b),
    .ready(ready), .done(done), .uart_wr(uart_wr), .uart_d(uart_d), .uart_ready(uart_ready));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset) begin
      if (uart_wr) begin
        rx.push_back(uart_d);
        if (last_wr >= 0 && cyc - last_wr != 2) bad_sp++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        done_gap = cyc - last_wr;
      end
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input logic [8:0] a, input logic [8:0] b, input string exp, input int mode);
    int t;
    bit flag;
    flag = 0;
    rx.delete();
    done_cnt = 0;
    bad_sp = 0;
    last_wr = -1;
    first_wr = -1;
    done_gap = -1;
    t = 0;
    while (!ready && t < 50) begin
      tick;
      t++;
    end
    check({tag, " ready_before"}, ready, 1);
    board_a = a;
    board_b = b;
    req = 1;
    tick;
    acc = cyc;
    req = 0;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      tick;
      t++;
      if (mode == 1 && !flag && rx.size() == 3) begin
        flag = 1;
        uart_ready = 0;
        repeat (5) tick;
        check({tag, " stall_no_wr"}, rx.size(), 3);
        uart_ready = 1;
      end
      if (mode == 2 && !flag && rx.size() == 6) begin
        flag = 1;
        reset = 1;
        tick;
        check({tag, " rst_wr"}, uart_wr, 0);
        check({tag, " rst_ready"}, ready, 0);
        tick;
        reset = 0;
        repeat (40) tick;
        check({tag, " rst_bytes"}, rx.size(), 6);
        check({tag, " rst_done"}, done_cnt, 0);
        return;
      end
      if (mode == 3 && !flag && rx.size() == 5) begin
        flag = 1;
        board_a = '1;
        req = 1;
        tick;
        check({tag, " busy_ready"}, ready, 0);
        req = 0;
      end
    end
    repeat (40) tick;
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " len"}, rx.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rx.size(); i++)
      check($sformatf("%s byte%0d", tag, i), rx[i], exp[i]);
    if (mode != 1) begin
      check({tag, " spacing"}, bad_sp, 0);
      check({tag, " done_gap"}, done_gap, 2);
      check({tag, " latency"}, first_wr - acc, 1);
    end
    check({tag, " ready_after"}, ready, 1);
  endtask
  initial begin
    reset = 1;
    req = 0;
    uart_ready = 1;
    board_a = 0;
    board_b = 0;
    repeat (3) tick;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_wr", uart_wr, 0);
    check("rst_d", uart_d, 0);
    reset = 0;
    check("rel_ready", ready, 0);
    tick;
    check("idle_ready", ready, 1);
    run("t1_empty", 9'b0, 9'b0, "...\r\n...\r\n...\r\n", 0);
    run("t2_mix", 9'b000_010_001, 9'b100_000_010, "ox.\r\n.o.\r\n..x\r\n", 0);
    run("t3_stall", 9'b0, 9'b0, "...\r\n...\r\n...\r\n", 1);
    if (rx.size() > 3) check("t3_byte4_cr", rx[3], 8'h0D);
    else check("t3_byte4_cr", rx.size(), 4);
    run("t4_bad", 9'b000_010_000, 9'b000_010_000, "...\r\n.#.\r\n...\r\n", 0);
    run("t5_abort", 9'b0, 9'b0, "", 2);
    run("t5_after", 9'b000_010_001, 9'b100_000_010, "ox.\r\n.o.\r\n..x\r\n", 0);
    run("t6_busy", 9'b000_010_001, 9'b100_000_010, "ox.\r\n.o.\r\n..x\r\n", 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
